multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle control unit for the 32-bit core: it sequences fetch, decode, execute, memory and write-back around the instruction decoder and datapath. It consumes decoded class fields (bc, ct, opcode), owns the single shared memory port handshake, and waits on the iterative multiply/divide unit. It emits one-hot datapath strobes and a retired-instruction count.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- run_i  in  1  level; leaves IDLE, and resumes from HALT
- bc_i  in  2  instruction bits [31:30] from decoder (00 ALU, 01 mem, 10 flow, 11 system)
- ct_i  in  1  instruction bit [29] (ALU: 0 reg/1 imm; mem: 0 load/1 store; flow: 0 branch/1 jump)
- opcode_i  in  5  instruction bits [28:24]
- mem_ready_i  in  1  memory accepts/completes current request this cycle
- alu_done_i  in  1  iterative MUL/SMUL/DIV/IDIV result valid (1-cycle pulse)
- branch_taken_i  in  1  branch compare result, sampled in EXEC
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  store request (valid with mem_req_o)
- mem_sel_o  out  1  0 instruction address (PC), 1 data address (ALU result)
- ir_load_o  out  1  load instruction register
- alu_start_o  out  1  start pulse to iterative unit
- imm_sel_o  out  1  ALU operand B = immediate
- reg_we_o  out  1  register-file write enable
- wb_sel_o  out  1  0 ALU result, 1 load data
- pc_en_o  out  1  advance PC (one pulse per retired instruction)
- pc_sel_o  out  2  00 PC+4, 01 branch target (immediate), 10 jump target (jump_imm)
- halt_o  out  1  in HALT
- trap_o  out  1  illegal instruction seen; sticky
- retired_o  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXEC, EXEC_WAIT, MEM, WB, HALT, TRAP. Outputs Moore-decoded from state plus registered class/opcode latched in DECODE.
- IDLE: all strobes 0; run_i=1 -> FETCH.
- FETCH: mem_req_o=1, mem_sel_o=0; on mem_ready_i assert ir_load_o same cycle, -> DECODE; else stay.
- DECODE: latch bc/ct/opcode. Legal: ALU opcode 0..8 (ADD, ADDU, SUB, MUL, SMUL, DIV, IDIV, AND, OR); mem/flow any opcode; system opcode 0 NOP, 1 HALT. Else -> TRAP. Otherwise -> EXEC.
- EXEC: imm_sel_o=ct for ALU, 1 for mem. ALU opcode 3..6: alu_start_o pulse, -> EXEC_WAIT. ALU other -> WB. Mem -> MEM. Branch: pc_en_o=1, pc_sel_o=01 if branch_taken_i else 00, -> FETCH. Jump: pc_en_o, pc_sel_o=10, reg_we_o=1 (link), -> FETCH. NOP: pc_en_o -> FETCH. HALT: -> HALT.
- EXEC_WAIT: hold until alu_done_i -> WB; alu_start_o 0.
- MEM: mem_req_o=1, mem_sel_o=1, mem_we_o=ct. On mem_ready_i: load -> WB; store -> pc_en_o=1, -> FETCH.
- WB: reg_we_o=1, wb_sel_o=1 for load else 0, pc_en_o=1, -> FETCH.
- HALT: halt_o=1; run_i=1 -> pc_en_o pulse, -> FETCH (HALT retires on resume).
- TRAP: trap_o=1, no strobes; exit only by reset.
- retired_o increments on every pc_en_o cycle; wraps 2^CNT_W-1 -> 0.
- run_i low only gates IDLE and HALT; an instruction in flight completes.

## Timing
- Reset (async assert, any state): state IDLE, every output 0, retired_o 0; mem_req_o drops immediately even mid-handshake. Deassertion synchronised by top level.
- Cycles per instruction with mem_ready_i high on first request cycle: ALU single 4, ALU iterative 4+N (N = cycles to alu_done_i, alu_done_i earliest the cycle after alu_start_o), load 5, store 4, branch/jump/NOP 3. Each memory wait cycle adds 1.
- mem_req_o, mem_we_o, mem_sel_o stable while waiting; no request dropped before mem_ready_i.
- alu_done_i outside EXEC_WAIT ignored; mem_ready_i outside FETCH/MEM ignored.
- pc_en_o and ir_load_o never asserted in same cycle.

## Structure
- Package ctrl_pkg: bc class constants, opcode constants (OP_ADD..OP_OR, SYS_NOP, SYS_HALT), state enum, pc_sel encodings.
- Sub-module op_classifier: combinational legal/iterative/class decode from bc, ct, opcode; reused by the decoder check logic.

## Test plan
- ADD reg (0x00_0_00000 class), mem_ready_i tied 1 -> ir_load_o cycle 1, reg_we_o+pc_en_o cycle 4, retired_o=1.
- DIV (opcode 5), alu_done_i 6 cycles after start -> exactly one alu_start_o, reg_we_o one cycle after alu_done_i; retired_o +1.
- Load with mem_ready_i delayed 3 cycles in FETCH and 2 in MEM -> mem_req_o held throughout, wb_sel_o=1 in WB, 10 total cycles.
- Branch taken/not taken -> pc_sel_o 01 / 00 in EXEC, no reg_we_o; jump -> pc_sel_o 10, reg_we_o=1.
- ALU opcode 9 or system opcode 2 -> TRAP, trap_o=1 sticky, no pc_en_o; HALT then run_i -> halt_o until run_i, one pc_en_o.
- Reset asserted mid-MEM wait -> mem_req_o=0 asynchronously, retired_o=0; preload retired_o near max (CNT_W=4) -> wraps 15 -> 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: instruction classes,
// opcodes, PC source selects, FSM states and the classifier result record.
package ctrl_pkg;

    localparam logic [1:0] BC_ALU  = 2'b00;
    localparam logic [1:0] BC_MEM  = 2'b01;
    localparam logic [1:0] BC_FLOW = 2'b10;
    localparam logic [1:0] BC_SYS  = 2'b11;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDU = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MUL  = 5'd3;
    localparam logic [4:0] OP_SMUL = 5'd4;
    localparam logic [4:0] OP_DIV  = 5'd5;
    localparam logic [4:0] OP_IDIV = 5'd6;
    localparam logic [4:0] OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8;

    localparam logic [4:0] SYS_NOP  = 5'd0;
    localparam logic [4:0] SYS_HALT = 5'd1;

    localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
    localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
    localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_EXEC_WAIT,
        ST_MEM,
        ST_WB,
        ST_HALT,
        ST_TRAP
    } state_t;

    typedef struct packed {
        logic legal;
        logic isAlu;
        logic isIter;
        logic isLoad;
        logic isStore;
        logic isBranch;
        logic isJump;
        logic isNop;
        logic isHalt;
    } op_class_t;

endpackage

// File: rtl/op_classifier.sv
// Combinational instruction classifier: legality, iterative-ALU detection and
// one-hot class flags from the decoded bc/ct/opcode fields.
module op_classifier
    import ctrl_pkg::*;
(
    input  logic [1:0] bc_i,
    input  logic       ct_i,
    input  logic [4:0] opcode_i,
    output op_class_t  class_o
);

    always_comb begin
        class_o = '0;
        case (bc_i)
            BC_ALU: begin
                class_o.isAlu  = 1'b1;
                class_o.legal  = (opcode_i <= OP_OR);
                class_o.isIter = (opcode_i >= OP_MUL) && (opcode_i <= OP_IDIV);
            end
            BC_MEM: begin
                class_o.legal   = 1'b1;
                class_o.isLoad  = ~ct_i;
                class_o.isStore = ct_i;
            end
            BC_FLOW: begin
                class_o.legal    = 1'b1;
                class_o.isBranch = ~ct_i;
                class_o.isJump   = ct_i;
            end
            default: begin
                class_o.isNop  = (opcode_i == SYS_NOP);
                class_o.isHalt = (opcode_i == SYS_HALT);
                class_o.legal  = (opcode_i == SYS_NOP) || (opcode_i == SYS_HALT);
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/write-back sequencing,
// memory handshake, iterative-ALU wait and retired-instruction counting.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic [1:0]       bc_i,
    input  logic             ct_i,
    input  logic [4:0]       opcode_i,
    input  logic             mem_ready_i,
    input  logic             alu_done_i,
    input  logic             branch_taken_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             mem_sel_o,
    output logic             ir_load_o,
    output logic             alu_start_o,
    output logic             imm_sel_o,
    output logic             reg_we_o,
    output logic             wb_sel_o,
    output logic             pc_en_o,
    output logic [1:0]       pc_sel_o,
    output logic             halt_o,
    output logic             trap_o,
    output logic [CNT_W-1:0] retired_o
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_bc;
    logic             r_ct;
    logic [4:0]       r_op;
    logic [1:0]       w_clsBc;
    logic             w_clsCt;
    logic [4:0]       w_clsOp;
    op_class_t        w_cls;
    logic [CNT_W-1:0] r_retired;

    // One classifier serves both the legality check in DECODE (live fields)
    // and the class dispatch afterwards (latched fields).
    assign w_clsBc = (r_state == ST_DECODE) ? bc_i     : r_bc;
    assign w_clsCt = (r_state == ST_DECODE) ? ct_i     : r_ct;
    assign w_clsOp = (r_state == ST_DECODE) ? opcode_i : r_op;

    op_classifier u_classifier (
        .bc_i     (w_clsBc),
        .ct_i     (w_clsCt),
        .opcode_i (w_clsOp),
        .class_o  (w_cls)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bc      <= '0;
            r_ct      <= 1'b0;
            r_op      <= '0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_bc <= bc_i;
                r_ct <= ct_i;
                r_op <= opcode_i;
            end
            if (pc_en_o) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign retired_o = r_retired;

    always_comb begin
        w_next      = r_state;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_sel_o   = 1'b0;
        ir_load_o   = 1'b0;
        alu_start_o = 1'b0;
        imm_sel_o   = 1'b0;
        reg_we_o    = 1'b0;
        wb_sel_o    = 1'b0;
        pc_en_o     = 1'b0;
        pc_sel_o    = PC_SEL_SEQ;
        halt_o      = 1'b0;
        trap_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run_i) w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_load_o = 1'b1;
                    w_next    = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next = w_cls.legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                if (w_cls.isAlu) begin
                    imm_sel_o = r_ct;
                    if (w_cls.isIter) begin
                        alu_start_o = 1'b1;
                        w_next      = ST_EXEC_WAIT;
                    end else begin
                        w_next = ST_WB;
                    end
                end else if (w_cls.isLoad || w_cls.isStore) begin
                    imm_sel_o = 1'b1;
                    w_next    = ST_MEM;
                end else if (w_cls.isBranch) begin
                    pc_en_o  = 1'b1;
                    pc_sel_o = branch_taken_i ? PC_SEL_BRANCH : PC_SEL_SEQ;
                    w_next   = ST_FETCH;
                end else if (w_cls.isJump) begin
                    pc_en_o  = 1'b1;
                    pc_sel_o = PC_SEL_JUMP;
                    reg_we_o = 1'b1;
                    w_next   = ST_FETCH;
                end else if (w_cls.isNop) begin
                    pc_en_o = 1'b1;
                    w_next  = ST_FETCH;
                end else if (w_cls.isHalt) begin
                    w_next = ST_HALT;
                end else begin
                    w_next = ST_TRAP;
                end
            end
            ST_EXEC_WAIT: begin
                if (alu_done_i) w_next = ST_WB;
            end
            ST_MEM: begin
                mem_req_o = 1'b1;
                mem_sel_o = 1'b1;
                mem_we_o  = r_ct;
                if (mem_ready_i) begin
                    if (r_ct) begin
                        pc_en_o = 1'b1;
                        w_next  = ST_FETCH;
                    end else begin
                        w_next = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_we_o = 1'b1;
                wb_sel_o = w_cls.isLoad;
                pc_en_o  = 1'b1;
                w_next   = ST_FETCH;
            end
            ST_HALT: begin
                halt_o = 1'b1;
                if (run_i) begin
                    pc_en_o = 1'b1;
                    w_next  = ST_FETCH;
                end
            end
            ST_TRAP: begin
                trap_o = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
